// File: rtl/control_decode_pipe_if.sv
// Handshake and control bundle between the decode register, the ID/EX
// control stage and the EXE stage.
interface control_decode_pipe_if #(
    parameter int unsigned OPCODE_W   = 6,
    parameter int unsigned ALU_OP_W   = 4,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [OPCODE_W-1:0]   opcode;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic [REG_ADDR_W-1:0] dest;
    logic                  ex_ready;
    logic                  flush;
    logic                  out_valid;
    logic [ALU_OP_W+1:0]   exe_cmd;
    logic [1:0]            mem_cmd;
    logic                  wb_en;
    logic                  is_imm;
    logic [REG_ADDR_W-1:0] out_dest;
    logic                  illegal;
    logic                  hazard_stall;
    logic [CNT_W-1:0]      illegal_cnt;

    modport master (
        output in_valid, opcode, src1, src2, dest, ex_ready, flush,
        input  in_ready, out_valid, exe_cmd, mem_cmd, wb_en, is_imm, out_dest, illegal,
               hazard_stall, illegal_cnt
    );

    modport slave (
        input  in_valid, opcode, src1, src2, dest, ex_ready, flush,
        output in_ready, out_valid, exe_cmd, mem_cmd, wb_en, is_imm, out_dest, illegal,
               hazard_stall, illegal_cnt
    );
endinterface

// File: rtl/control_decode_pipe.sv
// Opcode-to-command decode feeding a registered ID/EX control stage with
// valid/ready handshake, load-use stall, flush and illegal-opcode counting.
module control_decode_pipe #(
    parameter int unsigned OPCODE_W         = 6,
    parameter int unsigned ALU_OP_W         = 4,
    parameter int unsigned REG_ADDR_W       = 5,
    parameter int unsigned CNT_W            = 8,
    parameter bit          ZERO_WB_SUPPRESS = 1'b1
) (
    input logic                    clk,
    input logic                    rst_n,
    control_decode_pipe_if.slave   bus
);

    localparam logic [OPCODE_W-1:0] OpNop  = OPCODE_W'('h00);
    localparam logic [OPCODE_W-1:0] OpAdd  = OPCODE_W'('h01);
    localparam logic [OPCODE_W-1:0] OpSub  = OPCODE_W'('h03);
    localparam logic [OPCODE_W-1:0] OpAnd  = OPCODE_W'('h05);
    localparam logic [OPCODE_W-1:0] OpOr   = OPCODE_W'('h06);
    localparam logic [OPCODE_W-1:0] OpNor  = OPCODE_W'('h07);
    localparam logic [OPCODE_W-1:0] OpXor  = OPCODE_W'('h08);
    localparam logic [OPCODE_W-1:0] OpSla  = OPCODE_W'('h09);
    localparam logic [OPCODE_W-1:0] OpSll  = OPCODE_W'('h0A);
    localparam logic [OPCODE_W-1:0] OpSra  = OPCODE_W'('h0B);
    localparam logic [OPCODE_W-1:0] OpSrl  = OPCODE_W'('h0C);
    localparam logic [OPCODE_W-1:0] OpAddi = OPCODE_W'('h20);
    localparam logic [OPCODE_W-1:0] OpSubi = OPCODE_W'('h21);
    localparam logic [OPCODE_W-1:0] OpLd   = OPCODE_W'('h24);
    localparam logic [OPCODE_W-1:0] OpSt   = OPCODE_W'('h25);
    localparam logic [OPCODE_W-1:0] OpBez  = OPCODE_W'('h28);
    localparam logic [OPCODE_W-1:0] OpBne  = OPCODE_W'('h29);
    localparam logic [OPCODE_W-1:0] OpJmp  = OPCODE_W'('h2A);

    localparam logic [1:0] MemNone = 2'b00;
    localparam logic [1:0] MemLoad = 2'b01;
    localparam logic [1:0] MemStore = 2'b10;

    typedef struct packed {
        logic [ALU_OP_W+1:0]   exe_cmd;
        logic [1:0]            mem_cmd;
        logic                  wb_en;
        logic                  is_imm;
        logic                  illegal;
        logic [REG_ADDR_W-1:0] dest;
    } stage_t;

    logic [ALU_OP_W-1:0] dec_alu;
    logic [1:0]          dec_br;
    logic [1:0]          dec_mem;
    logic                dec_wb;
    logic                dec_imm;
    logic                dec_illegal;
    logic                uses_src1;
    logic                uses_src2;

    stage_t              stage_q, stage_d, stage_dec;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                hazard;
    logic                ready;
    logic                accept;

    // Operation class: commands, write-back and source-register usage.
    always_comb begin
        dec_br      = 2'b00;
        dec_mem     = MemNone;
        dec_wb      = 1'b0;
        dec_imm     = 1'b0;
        dec_illegal = 1'b0;
        uses_src1   = 1'b0;
        uses_src2   = 1'b0;
        case (bus.opcode)
            OpNop: ;
            OpAdd, OpSub, OpAnd, OpOr, OpNor, OpXor, OpSla, OpSll, OpSra, OpSrl: begin
                dec_wb    = 1'b1;
                uses_src1 = 1'b1;
                uses_src2 = 1'b1;
            end
            OpAddi, OpSubi: begin
                dec_wb    = 1'b1;
                dec_imm   = 1'b1;
                uses_src1 = 1'b1;
            end
            OpLd: begin
                dec_mem   = MemLoad;
                dec_wb    = 1'b1;
                dec_imm   = 1'b1;
                uses_src1 = 1'b1;
            end
            OpSt: begin
                dec_mem   = MemStore;
                dec_imm   = 1'b1;
                uses_src1 = 1'b1;
                uses_src2 = 1'b1;
            end
            OpBez: begin
                dec_br    = 2'b01;
                dec_imm   = 1'b1;
                uses_src1 = 1'b1;
            end
            OpBne: begin
                dec_br    = 2'b10;
                dec_imm   = 1'b1;
                uses_src1 = 1'b1;
                uses_src2 = 1'b1;
            end
            OpJmp: begin
                dec_br    = 2'b11;
                dec_imm   = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // ALU operation; everything not listed (including illegal) is ADD/zero.
    always_comb begin
        dec_alu = '0;
        case (bus.opcode)
            OpSub, OpSubi: dec_alu = ALU_OP_W'(4'b0010);
            OpAnd:         dec_alu = ALU_OP_W'(4'b0100);
            OpOr:          dec_alu = ALU_OP_W'(4'b0101);
            OpNor:         dec_alu = ALU_OP_W'(4'b0110);
            OpXor:         dec_alu = ALU_OP_W'(4'b0111);
            OpSla, OpSll:  dec_alu = ALU_OP_W'(4'b1000);
            OpSra:         dec_alu = ALU_OP_W'(4'b1001);
            OpSrl:         dec_alu = ALU_OP_W'(4'b1010);
            default:       dec_alu = '0;
        endcase
    end

    always_comb begin
        stage_dec.exe_cmd = {dec_alu, dec_br};
        stage_dec.mem_cmd = dec_mem;
        stage_dec.wb_en   = dec_wb & ~(ZERO_WB_SUPPRESS & (bus.dest == '0));
        stage_dec.is_imm  = dec_imm;
        stage_dec.illegal = dec_illegal;
        stage_dec.dest    = bus.dest;
    end

    // A load in the stage whose result a dependent instruction needs next.
    assign hazard = bus.in_valid & valid_q & (stage_q.mem_cmd == MemLoad) &
                    (stage_q.dest != '0) &
                    ((uses_src1 & (bus.src1 == stage_q.dest)) |
                     (uses_src2 & (bus.src2 == stage_q.dest)));

    assign ready  = (~valid_q | bus.ex_ready) & ~hazard & ~bus.flush;
    assign accept = bus.in_valid & ready;

    always_comb begin
        stage_d = stage_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            stage_d = '0;
            valid_d = 1'b0;
        end else if (accept) begin
            stage_d = stage_dec;
            valid_d = 1'b1;
        end else if (bus.ex_ready | ~valid_q) begin
            stage_d = '0;
            valid_d = 1'b0;
        end
        if (accept && dec_illegal && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready     = ready;
    assign bus.hazard_stall = hazard;
    assign bus.out_valid    = valid_q;
    assign bus.exe_cmd      = stage_q.exe_cmd;
    assign bus.mem_cmd      = stage_q.mem_cmd;
    assign bus.wb_en        = stage_q.wb_en;
    assign bus.is_imm       = stage_q.is_imm;
    assign bus.illegal      = stage_q.illegal;
    assign bus.out_dest     = stage_q.dest;
    assign bus.illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_control_decode_pipe.sv
// Directed bench for control_decode_pipe: opcode table plus hand-written
// stall, hold, flush and counter-saturation sequences.
module tb_control_decode_pipe;

    localparam logic [5:0] ADD = 6'h01, SUB = 6'h03, AND_ = 6'h05, OR_ = 6'h06, NOR_ = 6'h07;
    localparam logic [5:0] XOR_ = 6'h08, SLA = 6'h09, SLL = 6'h0A, SRA = 6'h0B, SRL = 6'h0C;
    localparam logic [5:0] ADDI = 6'h20, SUBI = 6'h21, LD = 6'h24, ST = 6'h25;
    localparam logic [5:0] BEZ = 6'h28, BNE = 6'h29, JMP = 6'h2A, NOP = 6'h00, BAD = 6'h3F;

    typedef struct {
        logic [5:0] op;
        logic [4:0] s1;
        logic [4:0] s2;
        logic [4:0] d;
        logic [5:0] exe;
        logic [1:0] mem;
        logic       wb;
        logic       imm;
        logic       ill;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   exp_cnt;

    control_decode_pipe_if bus ();

    control_decode_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.src1     = s1;
        bus.src2     = s2;
        bus.dest     = d;
    endtask

    task automatic check_stage(input string tag, input logic v, input logic [5:0] exe,
                               input logic [1:0] mem, input logic wb, input logic imm,
                               input logic ill, input logic [4:0] d);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, ".exe_cmd"},   32'(bus.exe_cmd),   32'(exe));
        check({tag, ".mem_cmd"},   32'(bus.mem_cmd),   32'(mem));
        check({tag, ".wb_en"},     32'(bus.wb_en),     32'(wb));
        check({tag, ".is_imm"},    32'(bus.is_imm),    32'(imm));
        check({tag, ".illegal"},   32'(bus.illegal),   32'(ill));
        check({tag, ".out_dest"},  32'(bus.out_dest),  32'(d));
    endtask

    function automatic vec_t mk(logic [5:0] op, logic [4:0] d, logic [5:0] exe, logic [1:0] mem,
                                logic wb, logic imm, logic ill);
        vec_t v;
        v.op = op; v.s1 = 5'd1; v.s2 = 5'd2; v.d = d;
        v.exe = exe; v.mem = mem; v.wb = wb; v.imm = imm; v.ill = ill;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[21];
        vecs[0]  = mk(ADD,  5'd3,  6'b000000, 2'b00, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(SUB,  5'd5,  6'b001000, 2'b00, 1'b1, 1'b0, 1'b0);
        vecs[2]  = mk(AND_, 5'd6,  6'b010000, 2'b00, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mk(OR_,  5'd7,  6'b010100, 2'b00, 1'b1, 1'b0, 1'b0);
        vecs[4]  = mk(NOR_, 5'd8,  6'b011000, 2'b00, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(XOR_, 5'd9,  6'b011100, 2'b00, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(SLA,  5'd10, 6'b100000, 2'b00, 1'b1, 1'b0, 1'b0);
        vecs[7]  = mk(SLL,  5'd11, 6'b100000, 2'b00, 1'b1, 1'b0, 1'b0);
        vecs[8]  = mk(SRA,  5'd12, 6'b100100, 2'b00, 1'b1, 1'b0, 1'b0);
        vecs[9]  = mk(SRL,  5'd13, 6'b101000, 2'b00, 1'b1, 1'b0, 1'b0);
        vecs[10] = mk(ADDI, 5'd14, 6'b000000, 2'b00, 1'b1, 1'b1, 1'b0);
        vecs[11] = mk(SUBI, 5'd15, 6'b001000, 2'b00, 1'b1, 1'b1, 1'b0);
        vecs[12] = mk(LD,   5'd7,  6'b000000, 2'b01, 1'b1, 1'b1, 1'b0);
        vecs[13] = mk(ST,   5'd16, 6'b000000, 2'b10, 1'b0, 1'b1, 1'b0);
        vecs[14] = mk(BEZ,  5'd17, 6'b000001, 2'b00, 1'b0, 1'b1, 1'b0);
        vecs[15] = mk(BNE,  5'd18, 6'b000010, 2'b00, 1'b0, 1'b1, 1'b0);
        vecs[16] = mk(JMP,  5'd19, 6'b000011, 2'b00, 1'b0, 1'b1, 1'b0);
        vecs[17] = mk(NOP,  5'd20, 6'b000000, 2'b00, 1'b0, 1'b0, 1'b0);
        vecs[18] = mk(BAD,  5'd21, 6'b000000, 2'b00, 1'b0, 1'b0, 1'b1);
        vecs[19] = mk(ADD,  5'd0,  6'b000000, 2'b00, 1'b0, 1'b0, 1'b0);
        vecs[20] = mk(6'h02, 5'd22, 6'b000000, 2'b00, 1'b0, 1'b0, 1'b1);

        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.opcode   = '0;
        bus.src1     = '0;
        bus.src2     = '0;
        bus.dest     = '0;
        bus.ex_ready = 1'b1;
        bus.flush    = 1'b0;
        tick();
        tick();
        check_stage("reset", 1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        check("reset.illegal_cnt", 32'(bus.illegal_cnt), 32'd0);
        rst_n = 1'b1;
        #1;
        check("reset.in_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back stream, one instruction per cycle.
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].d);
            #1;
            check($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
            tick();
            if (vecs[i].ill) exp_cnt++;
            check_stage($sformatf("vec%0d", i), 1'b1, vecs[i].exe, vecs[i].mem, vecs[i].wb,
                        vecs[i].imm, vecs[i].ill, vecs[i].d);
        end
        check("table.illegal_cnt", 32'(bus.illegal_cnt), 32'(exp_cnt));
        bus.in_valid = 1'b0;
        tick();
        check("drain.out_valid", 32'(bus.out_valid), 32'd0);

        // Load-use on src1: one stall cycle, one bubble, then accept.
        drive(LD, 5'd1, 5'd2, 5'd4);
        tick();
        drive(ADD, 5'd4, 5'd2, 5'd8);
        #1;
        check("lu.hazard_stall", 32'(bus.hazard_stall), 32'd1);
        check("lu.in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("lu.bubble_valid", 32'(bus.out_valid), 32'd0);
        check("lu.bubble_mem", 32'(bus.mem_cmd), 32'd0);
        check("lu.hazard_clear", 32'(bus.hazard_stall), 32'd0);
        check("lu.ready_again", 32'(bus.in_ready), 32'd1);
        tick();
        check_stage("lu.add", 1'b1, 6'd0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd8);

        // Load-use on src2 via ST stalls; JMP ignores src1 so does not.
        drive(LD, 5'd1, 5'd2, 5'd5);
        tick();
        drive(ST, 5'd1, 5'd5, 5'd9);
        #1;
        check("lu2.hazard_stall", 32'(bus.hazard_stall), 32'd1);
        drive(JMP, 5'd5, 5'd2, 5'd9);
        #1;
        check("lu_jmp.hazard_stall", 32'(bus.hazard_stall), 32'd0);
        check("lu_jmp.in_ready", 32'(bus.in_ready), 32'd1);
        tick();

        // Load to r0 never stalls.
        drive(LD, 5'd1, 5'd2, 5'd0);
        tick();
        check("ld0.wb_en", 32'(bus.wb_en), 32'd0);
        drive(ADD, 5'd0, 5'd0, 5'd9);
        #1;
        check("ld0.hazard_stall", 32'(bus.hazard_stall), 32'd0);
        check("ld0.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_stage("ld0.add", 1'b1, 6'd0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd9);

        // Back-pressure: hold for 3 cycles, then swap on the same edge.
        drive(XOR_, 5'd1, 5'd2, 5'd6);
        tick();
        bus.ex_ready = 1'b0;
        drive(AND_, 5'd1, 5'd2, 5'd11);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("hold%0d.in_ready", i), 32'(bus.in_ready), 32'd0);
            tick();
            check_stage($sformatf("hold%0d", i), 1'b1, 6'b011100, 2'd0, 1'b1, 1'b0, 1'b0, 5'd6);
        end
        bus.ex_ready = 1'b1;
        #1;
        check("swap.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_stage("swap", 1'b1, 6'b010000, 2'd0, 1'b1, 1'b0, 1'b0, 5'd11);

        // Flush kills the XOR in stage and drops the presented SUBI.
        drive(XOR_, 5'd1, 5'd2, 5'd6);
        tick();
        drive(SUBI, 5'd1, 5'd2, 5'd10);
        bus.flush = 1'b1;
        #1;
        check("flush.in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check_stage("flush", 1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("flush.subi_dropped", 32'(bus.out_valid), 32'd0);

        // Flush together with a load-use stall: flush wins.
        drive(LD, 5'd1, 5'd2, 5'd4);
        tick();
        drive(ADD, 5'd4, 5'd2, 5'd8);
        bus.flush = 1'b1;
        #1;
        check("fh.hazard_stall", 32'(bus.hazard_stall), 32'd1);
        tick();
        check("fh.out_valid", 32'(bus.out_valid), 32'd0);
        check("fh.hazard_clear", 32'(bus.hazard_stall), 32'd0);
        bus.flush = 1'b0;
        #1;
        check("fh.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_stage("fh.add", 1'b1, 6'd0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd8);

        // Reset asserted mid-stall discards the stage.
        drive(LD, 5'd1, 5'd2, 5'd4);
        tick();
        drive(ADD, 5'd4, 5'd2, 5'd8);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_stall.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_stall.hazard", 32'(bus.hazard_stall), 32'd0);
        check("rst_stall.cnt", 32'(bus.illegal_cnt), 32'd0);
        rst_n = 1'b1;

        // Illegal counter saturation.
        exp_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            drive(BAD, 5'd1, 5'd2, 5'd3);
            tick();
            if (exp_cnt < 255) exp_cnt++;
            check($sformatf("ill%0d.illegal", i), 32'(bus.illegal), 32'd1);
            check($sformatf("ill%0d.exe_cmd", i), 32'(bus.exe_cmd), 32'd0);
            check($sformatf("ill%0d.cnt", i), 32'(bus.illegal_cnt), 32'(exp_cnt));
        end
        check("sat.cnt", 32'(bus.illegal_cnt), 32'd255);
        check("sat.mem_wb", 32'({bus.mem_cmd, bus.wb_en}), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.cnt", 32'(bus.illegal_cnt), 32'd0);
        check("rst_mid.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid.illegal", 32'(bus.illegal), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst.cnt", 32'(bus.illegal_cnt), 32'd1);
        bus.in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
